// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Steps a radix-2 FFT through its butterfly stages. Each stage is:
//   LOAD (2 cycles, control block clears counters / decodes stage_level),
//   RUN ((max_point_fft+1)*BFLY_CYCLES cycles, ena_fft_core),
//   DRAIN (DRAIN_CYCLES cycles, ena_fft_wait).
//   After the last stage, a one-cycle DONE pulse is issued.
//
//   All enable/status outputs are registered from the current state. They
//   therefore trail the state register by one clock. With start sampled on
//   cycle 0:
//     - LOAD is visible on cycles 1-2.
//     - RUN starts on cycle 3.
//   abort bypasses that lag and zeroes the enables on the very next edge.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          job request, honoured only in IDLE
//   abort_i          return to IDLE, clears stage_level, suppresses done
//   log2_n_i         transform size exponent, legal 1..11
//   stage_number_o   latched log2_n
//   stage_level_o    current stage index
//   max_point_fft_o  2^log2_n - 1
//   ena_fft_core_o   RUN window
//   ena_fft_wait_o   DRAIN window
//   ena_mul_fp_clk_o step pulse at phase MUL_PHASE during RUN/DRAIN
//   busy_o           not idle
//   done_o           final stage finished (1 cycle)
//   cfg_err_o        start refused for illegal log2_n (1 cycle)
module fft_stage_sequencer #(
  parameter int ADDR_WIDTH   = 12,
  parameter int BFLY_CYCLES  = 10,
  parameter int DRAIN_CYCLES = 32,
  parameter int MUL_PHASE    = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [3:0]            log2_n_i,
  output logic [3:0]            stage_number_o,
  output logic [3:0]            stage_level_o,
  output logic [ADDR_WIDTH-1:0] max_point_fft_o,
  output logic                  ena_fft_core_o,
  output logic                  ena_fft_wait_o,
  output logic                  ena_mul_fp_clk_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam int PW = (BFLY_CYCLES > 1) ? $clog2(BFLY_CYCLES) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  // Step counter holds 2^11 for the largest transform.
  localparam int SW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic core;
    logic wt;
    logic mul;
    logic busy;
    logic done;
  } ctl_t;

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q;
  logic [SW-1:0]         step_q;
  logic [DW-1:0]         drain_q;
  logic                  load_q;
  logic [3:0]            sn_q, lvl_q;
  logic [ADDR_WIDTH-1:0] max_q;
  ctl_t                  ctl_q, ctl_d;
  logic                  cfg_err_q;

  logic legal, accept, phase_wrap, run_end, drain_end, last_stage, stepping;

  assign legal      = (log2_n_i >= 4'd1) && (log2_n_i <= 4'd11);
  assign accept     = (state_q == S_IDLE) && start_i && legal && !abort_i;
  assign phase_wrap = (phase_q == PW'(BFLY_CYCLES - 1));
  assign run_end    = phase_wrap && (step_q == {1'b0, max_q});
  assign drain_end  = (drain_q == DW'(DRAIN_CYCLES - 1));
  assign last_stage = (lvl_q == sn_q - 4'd1);
  // Phase keeps running across the RUN->DRAIN boundary and is cleared
  // otherwise, so it is always 0 on the first RUN cycle.
  assign stepping   = (state_q inside {S_RUN, S_DRAIN}) && (state_d inside {S_RUN, S_DRAIN});

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && legal) state_d = S_LOAD;
      S_LOAD:  if (load_q) state_d = S_RUN;
      S_RUN:   if (run_end) state_d = S_DRAIN;
      S_DRAIN: if (drain_end) state_d = last_stage ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  // Output decode (registered below)
  always_comb begin
    ctl_d      = '0;
    ctl_d.core = (state_q == S_RUN);
    ctl_d.wt   = (state_q == S_DRAIN);
    ctl_d.mul  = (state_q inside {S_RUN, S_DRAIN}) && (phase_q == PW'(MUL_PHASE));
    ctl_d.busy = (state_q != S_IDLE);
    ctl_d.done = (state_q == S_DONE);
    if (abort_i) ctl_d = '0;
  end

  // Phase / step / drain / load counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      step_q  <= '0;
      drain_q <= '0;
      load_q  <= 1'b0;
    end else begin
      load_q  <= (state_q == S_LOAD) && !load_q;
      phase_q <= (stepping && !phase_wrap) ? phase_q + PW'(1) : '0;
      if (state_q == S_RUN) begin
        if (phase_wrap) step_q <= step_q + SW'(1);
      end else begin
        step_q <= '0;
      end
      drain_q <= ((state_q == S_DRAIN) && !drain_end) ? drain_q + DW'(1) : '0;
    end
  end

  // Output and job-configuration registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_q     <= '0;
      cfg_err_q <= 1'b0;
      sn_q      <= '0;
      lvl_q     <= '0;
      max_q     <= '0;
    end else begin
      ctl_q     <= ctl_d;
      cfg_err_q <= (state_q == S_IDLE) && start_i && !legal && !abort_i;
      if (accept) begin
        sn_q  <= log2_n_i;
        max_q <= (ADDR_WIDTH'(1) << log2_n_i) - ADDR_WIDTH'(1);
        lvl_q <= '0;
      end else if (abort_i) begin
        lvl_q <= '0;
      end else if ((state_q == S_DRAIN) && drain_end && !last_stage) begin
        lvl_q <= lvl_q + 4'd1;
      end
    end
  end

  assign stage_number_o   = sn_q;
  assign stage_level_o    = lvl_q;
  assign max_point_fft_o  = max_q;
  assign ena_fft_core_o   = ctl_q.core;
  assign ena_fft_wait_o   = ctl_q.wt;
  assign ena_mul_fp_clk_o = ctl_q.mul;
  assign busy_o           = ctl_q.busy;
  assign done_o           = ctl_q.done;
  assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer.
// Reference model: the expected output on any cycle is computed directly from
// the job timeline. k is the number of edges since the accepting edge, and
// P = 2 + N*BFLY + DRAIN. Directed jobs are followed by a randomized phase of
// start/abort/rst traffic.
module tb_fft_stage_sequencer;
  localparam int AW = 12;
  localparam int BF = 10;
  localparam int DR = 32;
  localparam int MP = 9;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [3:0]    log2_n;
  logic [3:0]    stage_number, stage_level;
  logic [AW-1:0] max_point_fft;
  logic          core, wt, mul, busy, done, cfg_err;

  fft_stage_sequencer #(
    .ADDR_WIDTH(AW), .BFLY_CYCLES(BF), .DRAIN_CYCLES(DR), .MUL_PHASE(MP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .log2_n_i(log2_n),
    .stage_number_o(stage_number), .stage_level_o(stage_level),
    .max_point_fft_o(max_point_fft), .ena_fft_core_o(core), .ena_fft_wait_o(wt),
    .ena_mul_fp_clk_o(mul), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model state
  bit act;
  int k, L, m_sn, m_max;
  bit m_cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int per(input int l);
    return 2 + (1 << l) * BF + DR;
  endfunction

  // Expected outputs k edges after the accepting edge of a size-2^l job.
  // lvl = -1 marks a stage-boundary drain cycle where stage_level is not checked.
  function automatic void model(input int kk, input int l, output bit e_core, output bit e_wt,
                                output bit e_mul, output bit e_busy, output bit e_done,
                                output int e_lvl);
    int n, p, off;
    n = 1 << l;
    p = per(l);
    e_core = 0; e_wt = 0; e_mul = 0; e_busy = 0; e_done = 0;
    e_lvl = l - 1;
    if (kk == 0) begin
      e_lvl = 0;
    end else if (kk <= l * p) begin
      off    = (kk - 1) % p;
      e_busy = 1;
      e_core = (off >= 2) && (off < 2 + n * BF);
      e_wt   = (off >= 2 + n * BF);
      e_mul  = (off >= 2) && (((off - 2) % BF) == MP);
      e_lvl  = (off < 2 + n * BF) ? (kk - 1) / p : -1;
    end else if (kk == l * p + 1) begin
      e_busy = 1;
      e_done = 1;
    end
  endfunction

  task automatic tick();
    bit e_core, e_wt, e_mul, e_busy, e_done;
    int e_lvl;
    @(posedge clk);
    cyc++;
    m_cfg = 0;
    if (rst) begin
      act = 0; m_sn = 0; m_max = 0;
    end else if (abort) begin
      act = 0;
    end else begin
      if (act) k++;
      if (start && (!act || k >= L * per(L) + 2)) begin
        if (log2_n >= 1 && log2_n <= 11) begin
          act = 1; k = 0; L = int'(log2_n);
          m_sn = L; m_max = (1 << L) - 1;
        end else begin
          m_cfg = 1;
        end
      end
    end
    #1;
    if (act) begin
      model(k, L, e_core, e_wt, e_mul, e_busy, e_done, e_lvl);
    end else begin
      e_core = 0; e_wt = 0; e_mul = 0; e_busy = 0; e_done = 0; e_lvl = 0;
    end
    chk("ena_fft_core", core, e_core);
    chk("ena_fft_wait", wt, e_wt);
    chk("ena_mul_fp_clk", mul, e_mul);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("cfg_err", cfg_err, m_cfg);
    chk("stage_number", stage_number, m_sn);
    chk("max_point_fft", max_point_fft, m_max);
    if (e_lvl >= 0) chk("stage_level", stage_level, e_lvl);
  endtask

  task automatic go(input int l);
    log2_n = 4'(l);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; log2_n = 4'd0;
    act = 0; k = 0; L = 1; m_sn = 0; m_max = 0; m_cfg = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    // log2_n=3: three stages, done at k=343
    go(3);
    repeat (per(3) * 3 + 1) tick();
    repeat (5) tick();

    // log2_n=1: single stage, done at k=55
    go(1);
    repeat (60) tick();

    // illegal sizes
    go(0);
    tick();
    go(12);
    repeat (3) tick();

    // ignored busy start, then abort inside stage 1 RUN
    go(4);
    repeat (150) tick();
    go(2);
    repeat (98) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (10) tick();

    // back-to-back: second start on the cycle after done
    go(3);
    repeat (per(3) * 3 + 1) tick();
    go(2);
    repeat (per(2) * 2 + 5) tick();

    // randomized traffic
    for (int i = 0; i < 20000; i++) begin
      rst   = ($urandom_range(0, 4999) == 0);
      abort = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) begin
        t = int'($urandom_range(0, 4));
        log2_n = (t == 0) ? 4'd0 : 4'(11 + t);
      end else begin
        log2_n = 4'($urandom_range(1, 5));
      end
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
